dot_feed_acc: RTL and testbench

DOT_FEED_ACC -- requirements
Module: dot_feed_acc

---
 rtl/dot_pkg.sv | 17 +
 rtl/dot_tag_pipe.sv | 35 +++
 rtl/dot_feed_acc.sv | 162 ++++++++++++++++
 tb/tb_dot_feed_acc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product feed/accumulate block:
// operand geometry, engine result width, default engine latency, FSM states.
package dot_pkg;

  localparam int DOT_N   = 128; // operand pairs per chunk
  localparam int OP_W    = 8;   // signed operand element width
  localparam int ENG_W   = 23;  // signed engine result width
  localparam int LAT_DEF = 9;   // default engine latency in cycles

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dot_state_e;

endpackage

// File: rtl/dot_tag_pipe.sv
// LAT-deep valid shift register that follows operands through the engine.
// Synchronous clear drops every in-flight tag at once.
module dot_tag_pipe #(
  parameter int LAT = 9
) (
  input  logic clk,
  input  logic clr,
  input  logic tag_in,
  output logic tag_out
);

  logic [LAT-1:0] pipe_q;
  logic [LAT-1:0] pipe_d;

  // Shift the tags by one stage per cycle.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Tag register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/dot_feed_acc.sv
// Feeds operand chunks from the operand buffer into a pipelined dot-product
// engine and accumulates the engine results into one signed job sum.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is held with stable payload until that edge.
// Optional feature: define DOT_FEED_SAT_EN to clamp the accumulator instead
// of letting it wrap in two's complement.
module dot_feed_acc
  import dot_pkg::*;
#(
  parameter int DOT    = DOT_N,
  parameter int LAT    = LAT_DEF,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [ADDR_W-1:0]      job_base,
  input  logic [CNT_W-1:0]       job_len,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [DOT*OP_W-1:0]    mem_rd_a,
  input  logic [DOT*OP_W-1:0]    mem_rd_b,
  output logic [DOT*OP_W-1:0]    eng_a,
  output logic [DOT*OP_W-1:0]    eng_b,
  input  logic [ENG_W-1:0]       eng_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       res_data,
  output logic                   busy,
  output dot_state_e             dbg_state
);

  localparam int VEC_W = DOT * OP_W;
  localparam int OUT_W = CNT_W + 1;

  dot_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              rd_vld_q, rd_vld_d;
  logic              eng_tag_q, eng_tag_d;
  logic [VEC_W-1:0]  eng_a_q, eng_a_d;
  logic [VEC_W-1:0]  eng_b_q, eng_b_d;

  logic              issue;
  logic              job_acc;
  logic              tag_dly;
  logic [ACC_W:0]    sum_wide;

  // Engine result tag, aligned with eng_dout.
  dot_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk     (clk),
    .clr     (rst),
    .tag_in  (eng_tag_q),
    .tag_out (tag_dly)
  );

  // One-bit-wider sum so overflow can be detected for saturation.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-ENG_W){eng_dout[ENG_W-1]}}, eng_dout};
  end

  // Next-state, read issue, outstanding count, accumulate and engine feed.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    issue     = (state_q == ISSUE);
    job_acc   = job_valid && (state_q == IDLE);

    out_d = out_q + OUT_W'(issue) - OUT_W'(tag_dly);

    if (tag_dly) begin
`ifdef DOT_FEED_SAT_EN
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
        acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
`else
      acc_d = sum_wide[ACC_W-1:0];
`endif
    end

    case (state_q)
      IDLE: begin
        if (job_acc) begin
          addr_d  = job_base;
          rem_d   = job_len;
          acc_d   = '0;
          state_d = (job_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_vld_d  = issue;
    eng_tag_d = rd_vld_q;
    eng_a_d   = rd_vld_q ? mem_rd_a : eng_a_q;
    eng_b_d   = rd_vld_q ? mem_rd_b : eng_b_q;
  end

  // State, counters, accumulator and engine operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      acc_q     <= '0;
      rd_vld_q  <= 1'b0;
      eng_tag_q <= 1'b0;
      eng_a_q   <= '0;
      eng_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      acc_q     <= acc_d;
      rd_vld_q  <= rd_vld_d;
      eng_tag_q <= eng_tag_d;
      eng_a_q   <= eng_a_d;
      eng_b_q   <= eng_b_d;
    end
  end

  assign job_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign eng_a       = eng_a_q;
  assign eng_b       = eng_b_q;
  assign res_valid   = (state_q == DONE);
  assign res_data    = acc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dot_feed_acc.sv
// Directed bench for dot_feed_acc with an operand buffer model and a
// LAT-cycle dot-product engine model.
module tb_dot_feed_acc;
  import dot_pkg::*;

  localparam int DOT    = 128;
  localparam int LAT    = 9;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int ACC_W  = 24;
  localparam int VEC_W  = DOT * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [ADDR_W-1:0] job_base = '0;
  logic [CNT_W-1:0]  job_len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [VEC_W-1:0]  mem_rd_a;
  logic [VEC_W-1:0]  mem_rd_b;
  logic [VEC_W-1:0]  eng_a;
  logic [VEC_W-1:0]  eng_b;
  logic [22:0]       eng_dout;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ACC_W-1:0]  res_data;
  logic              busy;
  dot_state_e        dbg_state;

  int checks = 0;
  int failures = 0;

  logic [VEC_W-1:0] mem_a [0:1023];
  logic [VEC_W-1:0] mem_b [0:1023];
  logic [22:0]      eng_pipe [0:LAT-1];
  int               rd_q[$];
  int               rd_count = 0;

  dot_feed_acc #(
    .DOT(DOT), .LAT(LAT), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base(job_base), .job_len(job_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_a(mem_rd_a), .mem_rd_b(mem_rd_b),
    .eng_a(eng_a), .eng_b(eng_b), .eng_dout(eng_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- operand buffer model: 1-cycle read ----------------
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_a <= mem_a[mem_rd_addr];
      mem_rd_b <= mem_b[mem_rd_addr];
      rd_q.push_back(int'(mem_rd_addr));
      rd_count = rd_count + 1;
    end
  end

  // ---------------- engine model: dot product, LAT cycles ----------------
  function automatic logic [22:0] dot_fn(input logic [VEC_W-1:0] a,
                                         input logic [VEC_W-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < DOT; i++) begin
      s = s + int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    end
    return s[22:0];
  endfunction

  always @(posedge clk) begin
    eng_pipe[0] <= dot_fn(eng_a, eng_b);
    for (int i = 1; i < LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign eng_dout = eng_pipe[LAT-1];

  // ---------------- driver tasks ----------------
  task automatic fill(input int addr, input logic [7:0] av, input logic [7:0] bv);
    logic [VEC_W-1:0] va, vb;
    for (int i = 0; i < DOT; i++) begin
      va[8*i +: 8] = av;
      vb[8*i +: 8] = bv;
    end
    mem_a[addr] = va;
    mem_b[addr] = vb;
  endtask

  // Presents a job for one cycle at a negedge and returns the cycle index
  // (accept cycle = 0) of the first res_valid, or -1 if none within budget.
  task automatic run_job(input int base, input int len, input int budget,
                         output int lat);
    lat = -1;
    job_base  = ADDR_W'(base);
    job_len   = CNT_W'(len);
    job_valid = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) job_valid = 1'b0;
      if (res_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_data !== '0 || mem_rd_en !== 1'b0 ||
        busy !== 1'b0 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got rv=%b rd=%0d en=%b busy=%b jr=%b, want 0 0 0 0 1",
               res_valid, res_data, mem_rd_en, busy, job_ready);
    end
    checks++;
    if (eng_a !== '0 || eng_b !== '0) begin
      failures++;
      $display("FAIL reset_eng: eng_a/eng_b not zero");
    end
    rd_q.delete();
    rd_count = 0;
  endtask

  task automatic test_single();
    int lat;
    fill(5, 8'sd1, 8'sd2);
    run_job(5, 1, 60, lat);
    checks++;
    if (lat !== 13) begin
      failures++;
      $display("FAIL single_latency: got %0d want 13", lat);
    end
    checks++;
    if ($signed(res_data) !== 256) begin
      failures++;
      $display("FAIL single_data: got %0d want 256", $signed(res_data));
    end
    take_result();
    checks++;
    if (busy !== 1'b0 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_release: got busy=%b jr=%b want 0 1", busy, job_ready);
    end
  endtask

  task automatic test_wrap();
    int lat;
    fill(1022, 8'sd1, 8'sd1);            // 128
    fill(1023, 8'sd2, 8'sd3);            // 768
    fill(0, 8'hFF, 8'sd1);               // -128
    rd_q.delete();
    run_job(1022, 3, 60, lat);
    checks++;
    if (lat !== 15) begin
      failures++;
      $display("FAIL wrap_latency: got %0d want 15", lat);
    end
    checks++;
    if (rd_q.size() !== 3 || rd_q[0] !== 1022 || rd_q[1] !== 1023 || rd_q[2] !== 0) begin
      failures++;
      $display("FAIL wrap_addrs: got n=%0d first=%0d want 1022,1023,0",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1);
    end
    checks++;
    if ($signed(res_data) !== 768) begin
      failures++;
      $display("FAIL wrap_data: got %0d want 768", $signed(res_data));
    end
    take_result();
  endtask

  task automatic test_zero_len();
    int lat;
    int n0;
    n0 = rd_count;
    run_job(7, 0, 20, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL zero_latency: got %0d want 1", lat);
    end
    checks++;
    if (res_data !== '0) begin
      failures++;
      $display("FAIL zero_data: got %0d want 0", $signed(res_data));
    end
    checks++;
    if (rd_count !== n0) begin
      failures++;
      $display("FAIL zero_reads: got %0d reads want 0", rd_count - n0);
    end
    take_result();
  endtask

  task automatic test_saturate();
    int lat;
    int exp_v;
    for (int a = 10; a < 14; a++) fill(a, 8'h80, 8'h80);
`ifdef DOT_FEED_SAT_EN
    exp_v = 8388607;
`else
    exp_v = -8388608;
`endif
    run_job(10, 4, 60, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL sat_latency: got %0d want 16", lat);
    end
    checks++;
    if ($signed(res_data) !== exp_v) begin
      failures++;
      $display("FAIL sat_data: got %0d want %0d", $signed(res_data), exp_v);
    end
    take_result();
  endtask

  task automatic test_reset_drain();
    int lat;
    int seen;
    bit hit;
    fill(20, 8'sd3, 8'sd3);
    fill(21, 8'sd3, 8'sd3);
    fill(22, 8'sd1, 8'sd1);
    job_base = 10'd20; job_len = 8'd2; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (dbg_state == DRAIN) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_drain_reached: DRAIN not seen");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_result: got %0d res_valid cycles want 0", seen);
    end
    run_job(22, 1, 60, lat);
    checks++;
    if (lat !== 13 || $signed(res_data) !== 128) begin
      failures++;
      $display("FAIL abort_next_job: got lat=%0d data=%0d want 13 128",
               lat, $signed(res_data));
    end
    take_result();
  endtask

  task automatic test_hold_done();
    int lat;
    int n0;
    int bad;
    fill(30, 8'sd2, 8'sd2);              // 512
    run_job(30, 1, 60, lat);
    checks++;
    if (lat !== 13) begin
      failures++;
      $display("FAIL hold_latency: got %0d want 13", lat);
    end
    n0 = rd_count;
    job_base = 10'd40; job_len = 8'd5; job_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if ($signed(res_data) !== 512 || job_ready !== 1'b0 ||
          res_valid !== 1'b1 || dbg_state !== DONE) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (dbg_state !== IDLE || job_ready !== 1'b1 || rd_count !== n0) begin
      failures++;
      $display("FAIL hold_no_accept: got state=%0d jr=%b reads=%0d want 0 1 0",
               dbg_state, job_ready, rd_count - n0);
    end
    job_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (eng_a !== mem_a[30] || eng_b !== mem_b[30]) begin
      failures++;
      $display("FAIL eng_hold: eng_a/eng_b changed after last chunk");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < LAT; i++) eng_pipe[i] = '0;
    mem_rd_a = '0;
    mem_rd_b = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_wrap();
    test_zero_len();
    test_saturate();
    test_reset_drain();
    test_hold_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
